// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline latch with 2-entry skid buffer, flush, optional PIPE_STAGE_STATS_EN counters
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] xfer_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t state;
    logic [DATA_W-1:0] skid;
    logic acc, rel;
    assign acc = in_valid & in_ready;
    assign rel = out_valid & out_ready;
    if (DATA_W < 1 || DATA_W > 256 || STAT_W < 1) begin : g_bad_param
        $error("pipe_stage_skid: illegal DATA_W/STAT_W");
    end
    always_ff @(posedge clk) begin
        if (!clr || flush) begin
            state     <= EMPTY;
            out_data  <= '0;
            skid      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (acc) begin
                    out_data  <= in_data;
                    out_valid <= 1'b1;
                    state     <= ONE;
                end
                ONE: if (acc && !rel) begin
                    skid     <= in_data;
                    in_ready <= 1'b0;
                    state    <= TWO;
                end else if (acc) begin
                    out_data <= in_data;
                end else if (rel) begin
                    out_valid <= 1'b0;
                    state     <= EMPTY;
                end
                TWO: if (rel) begin
                    out_data <= skid;
                    in_ready <= 1'b1;
                    state    <= ONE;
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= EMPTY;
                end
            endcase
        end
    end
`ifdef PIPE_STAGE_STATS_EN
    always_ff @(posedge clk) begin
        if (!clr) begin
            stall_cnt <= '0;
            xfer_cnt  <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (rel && xfer_cnt != '1) xfer_cnt <= xfer_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed + random stimulus against a 2-deep FIFO reference model
module tb_pipe_stage_skid;
`ifdef PIPE_STAGE_STATS_EN
    localparam int DW = 8;
    localparam int SW = 4;
`else
    localparam int DW = 32;
    localparam int SW = 16;
`endif
    logic clk = 1'b0, clr = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic in_ready, out_valid;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [SW-1:0] stall_cnt, xfer_cnt;
`endif
    int total = 0, bad = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] held = '0;
    int m_stall = 0, m_xfer = 0;
    always #5 clk = ~clk;
    pipe_stage_skid #(.DATA_W(DW), .STAT_W(SW)) dut (
        .clk(clk), .clr(clr), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt(stall_cnt), .xfer_cnt(xfer_cnt)
`endif
    );
    function automatic int sat(int v);
        return (v == (1 << SW) - 1) ? v : v + 1;
    endfunction
    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        bit acc, rel;
        int n;
        n = q.size();
        acc = in_valid && n < 2;
        rel = n > 0 && out_ready;
        @(posedge clk);
        #1;
        if (!clr) begin
            q.delete();
            held = '0;
            m_stall = 0;
            m_xfer = 0;
        end else begin
            if (n > 0 && !out_ready) m_stall = sat(m_stall);
            if (rel) m_xfer = sat(m_xfer);
            if (flush) begin
                q.delete();
                held = '0;
            end else begin
                if (rel) void'(q.pop_front());
                if (acc) q.push_back(in_data);
            end
        end
        if (q.size() > 0) held = q[0];
        chk("in_ready", 256'(in_ready), 256'(q.size() < 2));
        chk("out_valid", 256'(out_valid), 256'(q.size() > 0));
        chk("out_data", 256'(out_data), 256'(held));
`ifdef PIPE_STAGE_STATS_EN
        chk("stall_cnt", 256'(stall_cnt), 256'(m_stall));
        chk("xfer_cnt", 256'(xfer_cnt), 256'(m_xfer));
`endif
    endtask
    initial begin
        in_valid = 1'b1;
        in_data = DW'(32'hDEAD_BEEF);
        tick();
        tick();
        clr = 1'b1;
        in_data = DW'(32'h11);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data = DW'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = DW'(8'hA);
        tick();
        in_data = DW'(8'hB);
        tick();
        in_data = DW'(8'hC);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = DW'(8'h1);
        tick();
        in_data = DW'(8'h2);
        tick();
        in_data = DW'(8'h55);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data = DW'(8'h7);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data = DW'(8'h9);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        clr = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data = DW'($urandom);
            flush = ($urandom_range(0, 24) == 0);
            clr = ($urandom_range(0, 59) != 0);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-width inter-stage pipeline latches (F/D, D/X, X/M, M/W).
- Carries one opaque payload of DATA_W bits between two pipeline stages with a valid/ready handshake, flush, and a 2-entry skid buffer.
- Sustains full throughput while in_ready stays a registered signal, so stalls no longer need a global enable fan-out.
- Stages pack PC, IR, operands and control bits into the payload bus.

Parameters:
- DATA_W, 32: payload width in bits; legal range 1 to 256.
- STAT_W, 16: width of the statistics counters; used only when PIPE_STAGE_STATS_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  reset; synchronous, active-low.
- flush  input  1  kill all held entries; for branch mispredict or exception squash.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept; registered.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  payload in the main register is valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  main register payload.
- stall_cnt  output  STAT_W  present only with PIPE_STAGE_STATS_EN.
- xfer_cnt  output  STAT_W  present only with PIPE_STAGE_STATS_EN.

Behaviour:
- Storage is a main register (drives out_data) plus a skid register; each has its own valid bit.
- Definitions: acc = in_valid & in_ready; rel = out_valid & out_ready.
- States: EMPTY (no entries), ONE (main valid), TWO (main and skid valid).
- in_ready = 1 in EMPTY and ONE, 0 in TWO. It is driven from a register, with no combinational path from out_ready.
- out_valid = 1 in ONE and TWO. out_data is always the main register.
- EMPTY transitions:
  - acc: main <= in_data, go to ONE.
  - otherwise stay in EMPTY.
- ONE transitions:
  - acc & rel: main <= in_data, stay in ONE.
  - acc & !rel: skid <= in_data, go to TWO.
  - !acc & rel: go to EMPTY.
  - otherwise hold.
- TWO transitions:
  - rel: main <= skid, go to ONE.
  - otherwise hold. No acceptance is possible because in_ready = 0.
- Ordering: strict FIFO; no payload is ever dropped or duplicated outside flush.
- Latency: 1 cycle from acc to out_valid when the stage is empty.
- Throughput: 1 payload per cycle while out_ready stays high.
- Priority: clr > flush > handshake.
- clr low at a rising edge:
  - state goes to EMPTY; main, skid and both valid bits become 0; in_ready becomes 1.
  - Statistics counters become 0.
  - This applies mid-transfer too; any in-flight payload is lost.
- flush high at a rising edge:
  - state goes to EMPTY; main and skid payloads become 0; in_ready becomes 1.
  - The payload offered on in_data that cycle is discarded, even though in_ready was 1.
  - A rel in the same cycle still counts as completed downstream; the downstream stage has already sampled it.
- out_data while out_valid = 0 is 0 after reset or flush; otherwise it holds its last value. Downstream must ignore it.
- No combinational path from in_* to out_*.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined:
  - stall_cnt increments on each cycle with out_valid & !out_ready.
  - xfer_cnt increments on each rel.
  - Both counters saturate at 2^STAT_W-1 and clear on clr.
  - flush does not clear them.
- Undefined: both ports and counters are absent; no extra logic.

Test Plan:
- Reset: hold clr=0 for 2 cycles with in_valid=1, in_data=32'hDEAD_BEEF -> out_valid=0, out_data=0, in_ready=1. After release, the first accepted word appears on out_data the next cycle.
- Streaming: out_ready=1, push 0x1..0x8 on consecutive cycles -> out_data shows 0x1..0x8 on 8 consecutive cycles starting 1 cycle after the first push; in_ready stays 1 throughout.
- Skid:
  - Push 0xA then 0xB, with out_ready=0 from the cycle 0xA appears -> state TWO, in_ready=0, out_data=0xA.
  - Raise out_ready -> 0xA, then 0xB, released in order.
  - 0xC held on in_data during TWO is accepted only after in_ready returns to 1.
- Flush while TWO, with in_valid=1, in_data=0x55 -> next cycle out_valid=0, in_ready=1, out_data=0; 0x55 never appears downstream.
- Flush + release: ONE holding 0x7 with out_ready=1 and flush=1 in the same cycle -> 0x7 is counted as transferred (xfer_cnt+1 with stats on); the stage is EMPTY next cycle.
- Stats (DATA_W=8, STAT_W=4, macro defined): hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Then clr=0 -> both counters read 0.
